switch_allocator_rr: RTL and testbench

- Separable input-first switch allocator that shares the crossbar among the per-VC requesters of the input block.
- Each cycle it picks at most one VC per input port, then at most one input port per output port, honouring downstream on/off flow control.
- Grants are registered and drive the input ports' read-select (valid_sel/vc_sel) and the crossbar's per-output input select.
- Sits between the input block (requests, out_port), the VC allocator (downstream VC ids) and the crossbar.

---
 rtl/switch_allocator_rr_if.sv | 28 ++
 rtl/switch_allocator_rr.sv | 107 ++++++++++
 tb/tb_switch_allocator_rr.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/switch_allocator_rr_if.sv
// Switch allocator bundle: input-block requests, VC-allocator ids and flow control in;
// port read-selects and crossbar selects out.
interface switch_allocator_rr_if #(
  parameter int unsigned PORT_NUM = 5,
  parameter int unsigned VC_NUM   = 2
);
  localparam int unsigned SEL_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int unsigned VC_W  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  logic [PORT_NUM-1:0][VC_NUM-1:0]            request_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0][SEL_W-1:0] out_port_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0][VC_W-1:0]  downstream_vc_i;
  logic [PORT_NUM-1:0][VC_NUM-1:0]            on_off_i;
  logic [PORT_NUM-1:0]                        valid_sel_o;
  logic [PORT_NUM-1:0][VC_W-1:0]              vc_sel_o;
  logic [PORT_NUM-1:0]                        xb_valid_o;
  logic [PORT_NUM-1:0][SEL_W-1:0]             xb_sel_o;

  modport master (
    output request_i, out_port_i, downstream_vc_i, on_off_i,
    input  valid_sel_o, vc_sel_o, xb_valid_o, xb_sel_o
  );

  modport slave (
    input  request_i, out_port_i, downstream_vc_i, on_off_i,
    output valid_sel_o, vc_sel_o, xb_valid_o, xb_sel_o
  );
endinterface

// File: rtl/switch_allocator_rr.sv
// Separable input-first round-robin switch allocator with registered grants and a
// one-cycle hold-off mask on the VCs granted last cycle.
module switch_allocator_rr #(
  parameter int unsigned PORT_NUM = 5,
  parameter int unsigned VC_NUM   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  switch_allocator_rr_if.slave  bus
);
  localparam int unsigned SEL_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int unsigned VC_W  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  logic [PORT_NUM-1:0][VC_NUM-1:0] hold_q, hold_d;
  logic [PORT_NUM-1:0][VC_W-1:0]   in_ptr_q, in_ptr_d;
  logic [PORT_NUM-1:0][SEL_W-1:0]  out_ptr_q, out_ptr_d;
  logic [PORT_NUM-1:0]             valid_sel_q, valid_sel_d;
  logic [PORT_NUM-1:0][VC_W-1:0]   vc_sel_q, vc_sel_d;
  logic [PORT_NUM-1:0]             xb_valid_q, xb_valid_d;
  logic [PORT_NUM-1:0][SEL_W-1:0]  xb_sel_q, xb_sel_d;

  logic [PORT_NUM-1:0][VC_NUM-1:0] elig;
  logic [PORT_NUM-1:0]             s1_valid;
  logic [PORT_NUM-1:0][VC_W-1:0]   s1_vc;
  logic [PORT_NUM-1:0][SEL_W-1:0]  s1_op;

  // Stage 1: eligibility and per-input round-robin VC pick
  always_comb begin
    int v;
    v        = 0;
    elig     = '0;
    s1_valid = '0;
    s1_vc    = '0;
    s1_op    = '0;
    for (int ip = 0; ip < int'(PORT_NUM); ip++) begin
      for (int vc = 0; vc < int'(VC_NUM); vc++) begin
        if (bus.request_i[ip][vc] && !hold_q[ip][vc] &&
            (int'(bus.out_port_i[ip][vc]) < int'(PORT_NUM)) &&
            (int'(bus.downstream_vc_i[ip][vc]) < int'(VC_NUM))) begin
          elig[ip][vc] = bus.on_off_i[bus.out_port_i[ip][vc]][bus.downstream_vc_i[ip][vc]];
        end
      end
    end
    for (int ip = 0; ip < int'(PORT_NUM); ip++) begin
      for (int k = 0; k < int'(VC_NUM); k++) begin
        v = (int'(in_ptr_q[ip]) + k) % int'(VC_NUM);
        if (!s1_valid[ip] && elig[ip][v]) begin
          s1_valid[ip] = 1'b1;
          s1_vc[ip]    = VC_W'(v);
          s1_op[ip]    = bus.out_port_i[ip][v];
        end
      end
    end
  end

  // Stage 2: per-output round-robin among stage-1 winners; only final grants move pointers
  always_comb begin
    int ip;
    ip          = 0;
    valid_sel_d = '0;
    vc_sel_d    = '0;
    xb_valid_d  = '0;
    xb_sel_d    = '0;
    hold_d      = '0;
    in_ptr_d    = in_ptr_q;
    out_ptr_d   = out_ptr_q;
    for (int op = 0; op < int'(PORT_NUM); op++) begin
      for (int k = 0; k < int'(PORT_NUM); k++) begin
        ip = (int'(out_ptr_q[op]) + k) % int'(PORT_NUM);
        if (!xb_valid_d[op] && s1_valid[ip] && (int'(s1_op[ip]) == op)) begin
          xb_valid_d[op]          = 1'b1;
          xb_sel_d[op]            = SEL_W'(ip);
          valid_sel_d[ip]         = 1'b1;
          vc_sel_d[ip]            = s1_vc[ip];
          hold_d[ip][s1_vc[ip]]   = 1'b1;
          out_ptr_d[op]           = SEL_W'((ip + 1) % int'(PORT_NUM));
          in_ptr_d[ip]            = VC_W'((int'(s1_vc[ip]) + 1) % int'(VC_NUM));
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q      <= '0;
      in_ptr_q    <= '0;
      out_ptr_q   <= '0;
      valid_sel_q <= '0;
      vc_sel_q    <= '0;
      xb_valid_q  <= '0;
      xb_sel_q    <= '0;
    end else begin
      hold_q      <= hold_d;
      in_ptr_q    <= in_ptr_d;
      out_ptr_q   <= out_ptr_d;
      valid_sel_q <= valid_sel_d;
      vc_sel_q    <= vc_sel_d;
      xb_valid_q  <= xb_valid_d;
      xb_sel_q    <= xb_sel_d;
    end
  end

  assign bus.valid_sel_o = valid_sel_q;
  assign bus.vc_sel_o    = vc_sel_q;
  assign bus.xb_valid_o  = xb_valid_q;
  assign bus.xb_sel_o    = xb_sel_q;
endmodule

// File: tb/tb_switch_allocator_rr.sv
// Directed bench for switch_allocator_rr (5 ports, 2 VCs) with hand-computed grants.
module tb_switch_allocator_rr;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  switch_allocator_rr_if #(.PORT_NUM(5), .VC_NUM(2)) bus ();

  switch_allocator_rr #(.PORT_NUM(5), .VC_NUM(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] vs, input logic [31:0] vc,
                         input logic [31:0] xv, input logic [31:0] xs);
    chk({tag, ".valid_sel"}, 32'(bus.valid_sel_o), vs);
    chk({tag, ".vc_sel"},    32'(bus.vc_sel_o),    vc);
    chk({tag, ".xb_valid"},  32'(bus.xb_valid_o),  xv);
    chk({tag, ".xb_sel"},    32'(bus.xb_sel_o),    xs);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.request_i       = '0;
    bus.out_port_i      = '0;
    bus.downstream_vc_i = '0;
    bus.on_off_i        = '1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk_all(tag, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    clk    = 1'b0;
    rst    = 1'b1;
    checks = 0;
    errors = 0;
    clear_inputs();
    #1;
    chk_all("por", 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Single request: ip1/v0 -> op3
    bus.request_i[1][0]  = 1'b1;
    bus.out_port_i[1][0] = 3'd3;
    step();
    chk_all("single.g1", 32'h02, 32'h00, 32'h08, 32'h0200);
    step();
    chk_all("single.mask", 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    chk_all("single.g2", 32'h02, 32'h00, 32'h08, 32'h0200);
    clear_inputs();
    step();
    chk_all("single.idle", 32'h0, 32'h0, 32'h0, 32'h0);

    // Output contention: ip0, ip2, ip4 all to op2
    do_reset("rst.contend");
    bus.request_i[0][0] = 1'b1; bus.out_port_i[0][0] = 3'd2;
    bus.request_i[2][0] = 1'b1; bus.out_port_i[2][0] = 3'd2;
    bus.request_i[4][0] = 1'b1; bus.out_port_i[4][0] = 3'd2;
    step();
    chk_all("contend.c1", 32'h01, 32'h0, 32'h04, 32'h0000);
    step();
    chk_all("contend.c2", 32'h04, 32'h0, 32'h04, 32'h0080);
    step();
    chk_all("contend.c3", 32'h10, 32'h0, 32'h04, 32'h0100);
    step();
    chk_all("contend.c4", 32'h01, 32'h0, 32'h04, 32'h0000);
    clear_inputs();

    // VC fairness: ip1 v0 -> op0, v1 -> op3
    do_reset("rst.vcfair");
    bus.request_i[1][0] = 1'b1; bus.out_port_i[1][0] = 3'd0;
    bus.request_i[1][1] = 1'b1; bus.out_port_i[1][1] = 3'd3;
    step();
    chk_all("vcfair.c1", 32'h02, 32'h00, 32'h01, 32'h0001);
    step();
    chk_all("vcfair.c2", 32'h02, 32'h02, 32'h08, 32'h0200);
    step();
    chk_all("vcfair.c3", 32'h02, 32'h00, 32'h01, 32'h0001);
    step();
    chk_all("vcfair.c4", 32'h02, 32'h02, 32'h08, 32'h0200);
    clear_inputs();

    // Flow control: ip3/v1 -> op2 via downstream VC1, initially off
    do_reset("rst.flow");
    bus.on_off_i[2][1]        = 1'b0;
    bus.request_i[3][1]       = 1'b1;
    bus.out_port_i[3][1]      = 3'd2;
    bus.downstream_vc_i[3][1] = 1'b1;
    step();
    chk_all("flow.off1", 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    chk_all("flow.off2", 32'h0, 32'h0, 32'h0, 32'h0);
    bus.on_off_i[2][1] = 1'b1;
    step();
    chk_all("flow.on", 32'h08, 32'h08, 32'h04, 32'h00C0);
    clear_inputs();

    // Parallel matching plus a U-turn on ip4/v1
    do_reset("rst.par");
    bus.request_i[0][0] = 1'b1; bus.out_port_i[0][0] = 3'd1;
    bus.request_i[1][0] = 1'b1; bus.out_port_i[1][0] = 3'd2;
    bus.request_i[2][0] = 1'b1; bus.out_port_i[2][0] = 3'd0;
    bus.request_i[4][1] = 1'b1; bus.out_port_i[4][1] = 3'd4;
    step();
    chk_all("par.c1", 32'h17, 32'h10, 32'h17, 32'h4042);

    // Reset mid-grant: outputs clear at once, grant lost, priority restarts
    #2;
    rst = 1'b1;
    #1;
    chk_all("midrst", 32'h0, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk_all("midrst.after", 32'h17, 32'h10, 32'h17, 32'h4042);
    step();
    chk_all("par.masked", 32'h0, 32'h0, 32'h0, 32'h0);
    clear_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
